// File: rtl/flappy_pkg.sv
// Shared types and helpers for the Flappy Bird round controller.
package flappy_pkg;

  typedef enum logic [1:0] {OVER, COUNTDOWN, RUNNING} game_state_t;

  localparam int SCORE_W_DEFAULT = 8;
  localparam int PERIOD_W        = 16;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value,
                                          input logic [31:0] max_value);
    return (value >= max_value) ? max_value : value + 32'd1;
  endfunction

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// tick_divider: wrap counter 0..period-1; tick is high while the count sits at period-1.
module tick_divider
  import flappy_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                clear,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  localparam logic [PERIOD_W-1:0] ONE = 1;

  logic [PERIOD_W-1:0] cnt;

  // >= keeps the counter safe if the period shrinks under it.
  assign tick = (cnt >= period - ONE);

  // NOTE: sequential state uses non-blocking assignments only; mixing in blocking ones races against readers.
  always_ff @(posedge clk) begin
    if (reset || clear) cnt <= '0;
    else if (tick)      cnt <= '0;
    else                cnt <= cnt + ONE;
  end

endmodule

// File: rtl/game_sequencer.sv
// Flappy Bird round controller: OVER -> COUNTDOWN -> RUNNING -> OVER, plus strobes and scores.
// Optional scroll speed-up when SPEED_RAMP_EN is defined.
module game_sequencer
  import flappy_pkg::*;
#(
  parameter int SCROLL_PERIOD     = 32,
  parameter int GRAVITY_PERIOD    = 16,
  parameter int COUNT_PERIOD      = 64,
  parameter int COUNTDOWN_LEN     = 3,
  parameter int SPAWN_SCROLLS     = 8,
  parameter int SCORE_W           = SCORE_W_DEFAULT,
  parameter int MIN_SCROLL_PERIOD = 8,
  parameter int RAMP_STEP         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               up,
  input  logic               collision,
  input  logic               pipe_passed,
  output logic               done,
  output logic               counting,
  output logic               running,
  output logic [2:0]         cd_digit,
  output logic               scroll_tick,
  output logic               gravity_tick,
  output logic               flap,
  output logic               spawn_pipe,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] hi_score
);

  localparam logic [PERIOD_W-1:0] SCROLL_P   = PERIOD_W'(SCROLL_PERIOD);
  localparam logic [PERIOD_W-1:0] GRAVITY_P  = PERIOD_W'(GRAVITY_PERIOD);
  localparam logic [PERIOD_W-1:0] COUNT_P    = PERIOD_W'(COUNT_PERIOD);
  localparam logic [PERIOD_W-1:0] SPAWN_LAST = PERIOD_W'(SPAWN_SCROLLS - 1);
  localparam logic [PERIOD_W-1:0] ONE        = 1;
  localparam logic [SCORE_W-1:0]  SCORE_MAX  = {SCORE_W{1'b1}};

  game_state_t         state;
  logic                up_q;
  logic                up_rise;
  logic                live;
  logic                cd_wrap;
  logic                scroll_wrap;
  logic                gravity_wrap;
  logic                score_inc;
  logic [PERIOD_W-1:0] scroll_period;
  logic [PERIOD_W-1:0] spawn_cnt;

  assign up_rise   = up & ~up_q;
  assign done      = (state == OVER);
  assign counting  = (state == COUNTDOWN);
  assign running   = (state == RUNNING);

  // A collision cycle belongs to the crash, so it suppresses every strobe.
  assign live         = running & ~collision;
  assign scroll_tick  = live & scroll_wrap;
  assign gravity_tick = live & gravity_wrap;
  assign flap         = live & up_rise;
  assign spawn_pipe   = scroll_tick & (spawn_cnt == SPAWN_LAST);
  assign score_inc    = live & pipe_passed & (score != SCORE_MAX);

  tick_divider u_count_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != COUNTDOWN),
    .period (COUNT_P),
    .tick   (cd_wrap)
  );

  tick_divider u_scroll_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != RUNNING),
    .period (scroll_period),
    .tick   (scroll_wrap)
  );

  tick_divider u_gravity_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (state != RUNNING),
    .period (GRAVITY_P),
    .tick   (gravity_wrap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= OVER;
      up_q      <= 1'b0;
      cd_digit  <= 3'd0;
      score     <= '0;
      hi_score  <= '0;
      spawn_cnt <= '0;
    end else begin
      up_q <= up;
      case (state)
        OVER: begin
          if (up_rise) begin
            state    <= COUNTDOWN;
            cd_digit <= 3'(COUNTDOWN_LEN);
            score    <= '0;
          end
        end
        COUNTDOWN: begin
          if (cd_wrap) begin
            if (cd_digit == 3'd1) begin
              state     <= RUNNING;
              cd_digit  <= 3'd0;
              spawn_cnt <= '0;
            end else begin
              cd_digit <= cd_digit - 3'd1;
            end
          end
        end
        RUNNING: begin
          if (collision) begin
            state <= OVER;
            if (score > hi_score) hi_score <= score;
          end else begin
            if (score_inc) score <= SCORE_W'(sat_inc(32'(score), 32'(SCORE_MAX)));
            if (scroll_tick) spawn_cnt <= (spawn_cnt == SPAWN_LAST) ? '0 : spawn_cnt + ONE;
          end
        end
        default: state <= OVER;
      endcase
    end
  end

`ifdef SPEED_RAMP_EN
  localparam logic [PERIOD_W-1:0] MIN_P  = PERIOD_W'(MIN_SCROLL_PERIOD);
  localparam logic [PERIOD_W-1:0] STEP_P = PERIOD_W'(RAMP_STEP);

  logic [PERIOD_W-1:0] period_pending;
  logic [PERIOD_W-1:0] period_q;
  logic [31:0]         score_plus;

  assign score_plus    = 32'(score) + 32'd1;
  assign scroll_period = period_q;

  // The ramped period waits in period_pending and is only adopted at a scroll wrap.
  always_ff @(posedge clk) begin
    if (reset || (done && up_rise)) begin
      period_pending <= SCROLL_P;
      period_q       <= SCROLL_P;
    end else begin
      if (score_inc && (score_plus[2:0] == 3'd0))
        period_pending <= (period_pending >= MIN_P + STEP_P) ? period_pending - STEP_P : MIN_P;
      if (running && scroll_wrap) period_q <= period_pending;
    end
  end
`else
  assign scroll_period = SCROLL_P;
`endif

endmodule
